// File: rtl/store_lane_unit.sv
`default_nettype none
//------------------------------------------------------------------------------
// store_lane_unit : aligns sb/sh/sw data onto 32-bit little-endian byte lanes
//                   and writes it to data memory over a req/ack handshake.
// Optional macro STORE_RMW_EN : read-modify-write for memories without byte enables.
// Revision: 1.0
//------------------------------------------------------------------------------
module store_lane_unit #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              st_valid,
   output logic              st_ready,
   input  logic [ADDR_W-1:0] st_addr,
   input  logic [DATA_W-1:0] st_data,
   input  logic [1:0]        st_size,
   output logic              st_done,
   output logic              st_fault,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [3:0]        mem_be,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WRITE = 3'd1,
      S_RESP  = 3'd2,
      S_FAULT = 3'd3,
      S_READ  = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [DATA_W-1:0]   mem_wdata_q;
   logic [3:0]          mem_be_q;
   logic                w_legal;
   logic [3:0]          w_lane_be;
   logic [DATA_W-1:0]   w_lane_data;
   logic                w_accept;

   always_comb begin
      w_legal     = 1'b0;
      w_lane_be   = 4'b0000;
      w_lane_data = '0;
      case (st_size)
         2'b00: begin
            w_legal     = 1'b1;
            w_lane_be   = 4'b0001 << st_addr[1:0];
            w_lane_data = {4{st_data[7:0]}};
         end
         2'b01: begin
            w_legal     = ~st_addr[0];
            w_lane_be   = st_addr[1] ? 4'b1100 : 4'b0011;
            w_lane_data = {2{st_data[15:0]}};
         end
         2'b10: begin
            w_legal     = (st_addr[1:0] == 2'b00);
            w_lane_be   = 4'b1111;
            w_lane_data = st_data;
         end
         default: ;
      endcase
   end

   // RESP also accepts so a zero-wait store can be followed back-to-back.
   assign w_accept = st_valid && ((state_q == S_IDLE) || (state_q == S_RESP));

   always_comb begin
      state_d  = state_q;
      st_ready = 1'b0;
      st_done  = 1'b0;
      st_fault = 1'b0;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      case (state_q)
         S_IDLE, S_RESP: begin
            st_ready = 1'b1;
            st_done  = (state_q == S_RESP);
            state_d  = S_IDLE;
            if (st_valid) begin
               if (!w_legal)
                  state_d = S_FAULT;
`ifdef STORE_RMW_EN
               else if (st_size != 2'b10)
                  state_d = S_READ;
`endif
               else
                  state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            if (mem_ack)
               state_d = S_RESP;
         end
`ifdef STORE_RMW_EN
         S_READ: begin
            mem_req = 1'b1;
            if (mem_ack)
               state_d = S_WRITE;
         end
`endif
         S_FAULT: begin
            st_fault = 1'b1;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

`ifdef STORE_RMW_EN
   logic [3:0]        lane_q;
   logic [DATA_W-1:0] w_merged;

   always_comb begin
      w_merged = mem_rdata;
      for (int i = 0; i < 4; i++)
         if (lane_q[i])
            w_merged[8*i +: 8] = mem_wdata_q[8*i +: 8];
   end
`else
   logic unused_rdata;
   assign unused_rdata = ^mem_rdata;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= 4'b0000;
`ifdef STORE_RMW_EN
         lane_q      <= 4'b0000;
`endif
      end else begin
         state_q <= state_d;
         // Memory-side fields only move on a legal acceptance; faults leave them untouched.
         if (w_accept && w_legal) begin
            mem_addr_q  <= {st_addr[ADDR_W-1:2], 2'b00};
            mem_wdata_q <= w_lane_data;
`ifdef STORE_RMW_EN
            mem_be_q    <= 4'b1111;
            lane_q      <= w_lane_be;
`else
            mem_be_q    <= w_lane_be;
`endif
         end
`ifdef STORE_RMW_EN
         if ((state_q == S_READ) && mem_ack)
            mem_wdata_q <= w_merged;
`endif
      end
   end

   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_be    = mem_be_q;

endmodule
`default_nettype wire
